register_bank_write_arbiter: RTL

Arbitrates two write-back requesters (ALU result path and load path) onto the single write port of the processor's 16 x 32-bit register bank, which is built from per-register REGISTER_MODULE instances. It selects one request per cycle with round-robin fairness and acknowledges the winner with a one-cycle grant. It drives a one-hot WRITE enable per register plus shared write data.

---
 rtl/register_bank_write_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/register_bank_write_arbiter.sv
// Write-back arbiter for the 16 x 32-bit register bank.
// Two requesters share the bank's single write port: the ALU result path (A)
// and the load path (B). Fairness comes from a round-robin priority bit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no write this cycle, write_en_o all zero
// GRANT_A | A's latched write is on the port, gnt_a_o high
// GRANT_B | B's latched write is on the port, gnt_b_o high
module register_bank_write_arbiter #(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_SIZE = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      req_a_i,
   input  logic [ADDR_SIZE-1:0]      addr_a_i,
   input  logic [DATA_SIZE-1:0]      data_a_i,
   output logic                      gnt_a_o,
   input  logic                      req_b_i,
   input  logic [ADDR_SIZE-1:0]      addr_b_i,
   input  logic [DATA_SIZE-1:0]      data_b_i,
   output logic                      gnt_b_o,
   output logic [(1<<ADDR_SIZE)-1:0] write_en_o,
   output logic [DATA_SIZE-1:0]      write_data_o,
   output logic                      busy_o
);

   localparam int NUM_REGS = 1 << ADDR_SIZE;

   // Each grant state sets its own bit so the grant outputs come straight
   // off a flop with no decode behind them.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_A = 2'b01,
      GRANT_B = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic                  prio_q, prio_d;
   logic [NUM_REGS-1:0]   write_en_q, write_en_d;
   logic [DATA_SIZE-1:0]  write_data_q, write_data_d;
   logic                  ereq_a, ereq_b;

   // A requester is masked in its own grant cycle; it is busy retiring REQ.
   assign ereq_a = req_a_i & ~state_q[0];
   assign ereq_b = req_b_i & ~state_q[1];

   // State, priority and registered write port; reset drops write_en at once
   // so a grant interrupted by reset never reaches the bank.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         write_en_q   <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         write_en_q   <= write_en_d;
         write_data_q <= write_data_d;
      end
   end

   // Round-robin decision: prio_q = 0 favours A, and the winner hands
   // priority to the other side. Write data holds while idle.
   always_comb begin
      state_d      = IDLE;
      prio_d       = prio_q;
      write_en_d   = '0;
      write_data_d = write_data_q;
      if (ereq_a && (!ereq_b || !prio_q)) begin
         state_d      = GRANT_A;
         prio_d       = 1'b1;
         write_en_d   = NUM_REGS'(1) << addr_a_i;
         write_data_d = data_a_i;
      end else if (ereq_b) begin
         state_d      = GRANT_B;
         prio_d       = 1'b0;
         write_en_d   = NUM_REGS'(1) << addr_b_i;
         write_data_d = data_b_i;
      end
   end

   assign gnt_a_o      = state_q[0];
   assign gnt_b_o      = state_q[1];
   assign busy_o       = state_q != IDLE;
   assign write_en_o   = write_en_q;
   assign write_data_o = write_data_q;

endmodule
